multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Control unit for a multicycle MIPS-subset datapath: a Moore FSM that sequences
// fetch, decode, execute, memory access and write-back, plus the ALU decoder.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       lord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       memwrite,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       valid;
    logic [2:0] alu_dec;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        lord     = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        memwrite = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        valid    = 1'b1;
        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            DECODE:   alusrcb = 2'b11;
            MEMADR, ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:    lord = 1'b1;
            MEMWR: begin
                lord     = 1'b1;
                memwrite = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB:   regwrite = 1'b1;
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default:  valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_dec = 3'b010;
        case (aluop)
            2'b01:   alu_dec = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alu_dec = 3'b110;
                    6'b100100: alu_dec = 3'b000;
                    6'b100101: alu_dec = 3'b001;
                    6'b101010: alu_dec = 3'b111;
                    default:   alu_dec = 3'b010;
                endcase
            end
            default: alu_dec = 3'b010;
        endcase
    end

    // Unused encodings drive every output to 0, including the ALU code.
    assign alucontrol = valid ? alu_dec : 3'b000;
    assign pcen       = pcwrite | (branch & zero);
    assign state      = state_q;
endmodule
